err_compute_sm: RTL and testbench

ERR_COMPUTE_SM -- requirements
Module: err_compute_SM

---
 rtl/err_cmp_pkg.sv | 15 +
 rtl/err_compute_sm.sv | 87 ++++++++
 tb/tb_err_compute_sm.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/err_cmp_pkg.sv
// Shared types and constants for the error-compute controller and datapath.
package err_cmp_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StClr,
      StAccum,
      StDone
   } err_cmp_state_e;

   localparam int unsigned NUM_TERMS = 8;
   localparam int unsigned SEL_W     = 3;

endpackage

// File: rtl/err_compute_sm.sv
// Sequencer for the IR error accumulation: settle, clear, 8 add/subtract steps, result strobe.
// Build option ERR_CMP_RESTART_EN: IR_vld during SETTLE/CLR/ACCUM aborts and restarts the sequence.
module err_compute_sm
   import err_cmp_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             IR_vld,
   output logic             clr_accum,
   output logic             en_accum,
   output logic             sub,
   output logic [SEL_W-1:0] sel,
   output logic             err_vld,
   output logic             busy
);

   localparam bit         UseSettle  = (SETTLE_CYC > 0);
   localparam logic [3:0] SettleLoad = 4'(UseSettle ? SETTLE_CYC - 1 : 0);
   localparam logic [SEL_W-1:0] LastStep = SEL_W'(NUM_TERMS - 1);

   err_cmp_state_e   state_q, state_d;
   logic [3:0]       settle_cnt_q, settle_cnt_d;
   logic [SEL_W-1:0] step_q, step_d;
   logic             start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         settle_cnt_q <= '0;
         step_q       <= '0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         step_q       <= step_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      step_d       = step_q;

`ifdef ERR_CMP_RESTART_EN
      start = IR_vld && (state_q != StDone);
`else
      start = IR_vld && (state_q == StIdle);
`endif

      unique case (state_q)
         StIdle: ;
         StSettle: begin
            if (settle_cnt_q == '0) state_d = StClr;
            else                    settle_cnt_d = settle_cnt_q - 4'd1;
         end
         StClr: begin
            state_d = StAccum;
            step_d  = '0;
         end
         StAccum: begin
            step_d = step_q + 1'b1;
            if (step_q == LastStep) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // A (re)start overrides whatever the case decided; step restarts at 0.
      if (start) begin
         state_d      = UseSettle ? StSettle : StClr;
         settle_cnt_d = SettleLoad;
         step_d       = '0;
      end
   end

   // Outputs depend only on registered state, so IR_vld never reaches them combinationally.
   always_comb begin
      clr_accum = (state_q == StClr);
      en_accum  = (state_q == StAccum);
      err_vld   = (state_q == StDone);
      busy      = (state_q != StIdle);
      sel       = en_accum ? step_q : '0;
      sub       = en_accum & step_q[0];
   end

endmodule

// File: tb/tb_err_compute_sm.sv
// Scoreboard bench for err_compute_sm with SETTLE_CYC=0 and SETTLE_CYC=3 instances side by side.
module tb_err_compute_sm;

   logic clk = 1'b0;
   logic rst_n;
   logic IR_vld;

   logic       clr0, en0, sub0, vld0, busy0;
   logic [2:0] sel0;
   logic       clr3, en3, sub3, vld3, busy3;
   logic [2:0] sel3;

   int n_vec = 0;
   int n_err = 0;

   // Scoreboard entries: {busy, err_vld, clr_accum, en_accum, sub, sel[2:0]} per cycle.
   logic [7:0] q0[$];
   logic [7:0] q3[$];

   always #10 clk = ~clk;

   err_compute_sm #(.SETTLE_CYC(0)) u_dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .IR_vld    (IR_vld),
      .clr_accum (clr0),
      .en_accum  (en0),
      .sub       (sub0),
      .sel       (sel0),
      .err_vld   (vld0),
      .busy      (busy0)
   );

   err_compute_sm #(.SETTLE_CYC(3)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .IR_vld    (IR_vld),
      .clr_accum (clr3),
      .en_accum  (en3),
      .sub       (sub3),
      .sel       (sel3),
      .err_vld   (vld3),
      .busy      (busy3)
   );

   wire [7:0] obs0 = {busy0, vld0, clr0, en0, sub0, sel0};
   wire [7:0] obs3 = {busy3, vld3, clr3, en3, sub3, sel3};

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected outputs k cycles after a start is sampled (k = 1 .. s+10).
   function automatic logic [7:0] seq_vec(input int s, input int k);
      logic [2:0] j;
      if (k <= s)          return 8'h80;
      else if (k == s + 1) return 8'hA0;
      else if (k <= s + 9) begin
         j = 3'(k - s - 2);
         return {4'b1001, j[0], j};
      end
      return 8'hC0;
   endfunction

   // cur is the expectation for the cycle in which the pulse is sampled.
   task automatic accept(input int s, input logic [7:0] cur);
      bit take;
      take = (cur == 8'h00);
`ifdef ERR_CMP_RESTART_EN
      if (cur != 8'h00 && !cur[6]) take = 1'b1;
`endif
      if (take) begin
         if (s == 0) begin
            q0.delete();
            for (int k = 1; k <= 10; k++) q0.push_back(seq_vec(0, k));
         end else begin
            q3.delete();
            for (int k = 1; k <= 13; k++) q3.push_back(seq_vec(3, k));
         end
      end
   endtask

   task automatic run_cycle(input logic pulse, input string tag);
      logic [7:0] e0, e3;
      @(negedge clk);
      e0 = (q0.size() > 0) ? q0.pop_front() : 8'h00;
      e3 = (q3.size() > 0) ? q3.pop_front() : 8'h00;
      check({tag, "/s0"}, obs0, e0);
      check({tag, "/s3"}, obs3, e3);
      if (pulse) begin
         accept(0, e0);
         accept(3, e3);
      end
      IR_vld = pulse;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) run_cycle(1'b0, tag);
   endtask

   initial begin
      rst_n  = 1'b0;
      IR_vld = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset/s0", obs0, 8'h00);
      check("reset/s3", obs3, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Pulse on the first sampled edge after reset, then a full sequence.
      run_cycle(1'b1, "single");
      idle(16, "single");

      // Second pulse while sel=2 on the SETTLE_CYC=0 instance.
      run_cycle(1'b1, "restart");
      idle(3, "restart");
      run_cycle(1'b1, "restart");
      idle(18, "restart");

      // Pulses 0, 10 and 11 cycles apart: the one in DONE is dropped.
      run_cycle(1'b1, "b2b");
      idle(9, "b2b");
      run_cycle(1'b1, "b2b");
      run_cycle(1'b1, "b2b");
      idle(16, "b2b");

      // Asynchronous reset mid-sequence (sel=4 on the SETTLE_CYC=0 instance).
      run_cycle(1'b1, "arst");
      idle(6, "arst");
      #3 rst_n = 1'b0;
      #1;
      check("arst_now/s0", obs0, 8'h00);
      check("arst_now/s3", obs3, 8'h00);
      q0.delete();
      q3.delete();
      @(posedge clk);
      #1;
      check("arst_hold/s0", obs0, 8'h00);
      check("arst_hold/s3", obs3, 8'h00);
      @(negedge clk);
      rst_n  = 1'b1;
      IR_vld = 1'b0;
      run_cycle(1'b1, "post_rst");
      idle(16, "post_rst");

      // Sparse random pulses.
      for (int i = 0; i < 300; i++) run_cycle($urandom_range(0, 9) == 0, "rand");
      idle(16, "drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
